// File: rtl/rns_reverse_converter.sv
// rns_reverse_converter
//   Sequential residue-to-binary converter for the moduli set
//   {2^N-1, 2^N, 2^N+1}. It accepts one residue triple per valid/ready
//   handshake and returns X in [0, M), where M = 2^N*(2^(2N)-1).
//
//   X is rebuilt as X = r2 + 2^N*Y, with Y = X div 2^N in [0, m1*m3):
//     a = Y mod m1 = (r1 - r2) mod m1      (2^N == 1 mod m1)
//     b = Y mod m3 = (r2 - r3) mod m3      (2^N == -1 mod m3)
//     t = (b - a) * m1^-1 mod m3           (m1^-1 == 2^(N-1) mod m3)
//     Y = a + m1*t
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   residue triple present
//   in_ready   converter idle and able to accept
//   r1         residue mod 2^N-1 (all-ones is a non-canonical zero)
//   r2         residue mod 2^N
//   r3         residue mod 2^N+1, range 0..2^N
//   out_valid  result available
//   out_ready  consumer accepts result
//   x          reconstructed binary value (3N bits)
module rns_reverse_converter #(
  parameter int N = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   r1,
  input  logic [N-1:0]   r2,
  input  logic [N:0]     r3,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [3*N-1:0] x
);

  localparam int W = N + 2;
  localparam logic [N:0] M1   = (N+1)'((2**N) - 1);
  localparam logic [N:0] M3   = (N+1)'((2**N) + 1);
  localparam logic [N:0] HALF = (N+1)'(2**(N-1));

  typedef enum logic [2:0] {IDLE, SUB, DIF, MUL, SUM, DONE} state_t;

  // Modular subtraction (p - q) mod m for operands already in 0..m.
  // The raw difference and its corrected value (raw + m) are both formed;
  // the sign (borrow) of the raw difference selects between them.
  function automatic logic [N:0] mod_sub(input logic [N:0] p,
                                         input logic [N:0] q,
                                         input logic [N:0] m);
    logic signed [W-1:0] raw;
    logic signed [W-1:0] cor;
    raw = $signed({1'b0, p}) - $signed({1'b0, q});
    cor = raw + $signed({1'b0, m});
    return raw[W-1] ? cor[N:0] : raw[N:0];
  endfunction

  // (d * 2^(N-1)) mod m3 without a multiplier. With d = 2h + l:
  //   l = 0 : h*2^N        == -h           -> m3 - h (0 when h = 0)
  //   l = 1 : h*2^N + 2^(N-1) == 2^(N-1) - h (h < 2^(N-1), never negative)
  function automatic logic [N:0] mul_half(input logic [N:0] d);
    logic [N:0] h;
    h = d >> 1;
    if (d[0])
      return HALF - h;
    else if (h == '0)
      return '0;
    else
      return M3 - h;
  endfunction

  state_t           r_state;
  logic [N-1:0]     r_r1_p0;
  logic [N-1:0]     r_r2_p0;
  logic [N:0]       r_r3_p0;
  logic [N:0]       r_a_p1;
  logic [N:0]       r_b_p1;
  logic [N:0]       r_d_p2;
  logic [N:0]       r_t_p3;
  logic [3*N-1:0]   r_x;
  logic             r_out_valid;

  logic [N-1:0]     w_r1n;
  logic [N:0]       w_a;
  logic [N:0]       w_b;
  logic [N:0]       w_d;
  logic [N:0]       w_t;
  logic [2*N-1:0]   w_y;

  // Fold the non-canonical all-ones residue of m1 onto zero.
  assign w_r1n = (r_r1_p0 == M1[N-1:0]) ? '0 : r_r1_p0;
  assign w_a   = mod_sub({1'b0, w_r1n}, {1'b0, r_r2_p0}, M1);
  assign w_b   = mod_sub({1'b0, r_r2_p0}, r_r3_p0, M3);
  assign w_d   = mod_sub(r_b_p1, r_a_p1, M3);
  assign w_t   = mul_half(r_d_p2);
  // m1*t = (t << N) - t. Y < 2^(2N)-1, so wrapping 2N-bit arithmetic
  // yields the exact value even though t << N alone may overflow.
  assign w_y   = (2*N)'(r_a_p1) + ((2*N)'(r_t_p3) << N) - (2*N)'(r_t_p3);

  // Gated by rst so the converter never advertises readiness while held
  // in reset, yet is ready in the very first cycle after release.
  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign x         = r_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_r1_p0     <= '0;
      r_r2_p0     <= '0;
      r_r3_p0     <= '0;
      r_a_p1      <= '0;
      r_b_p1      <= '0;
      r_d_p2      <= '0;
      r_t_p3      <= '0;
      r_x         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        // p0: capture the residue triple
        IDLE: begin
          if (in_valid) begin
            r_r1_p0 <= r1;
            r_r2_p0 <= r2;
            r_r3_p0 <= r3;
            r_state <= SUB;
          end
        end
        // p1: residues of Y modulo m1 and m3
        SUB: begin
          r_a_p1  <= w_a;
          r_b_p1  <= w_b;
          r_state <= DIF;
        end
        // p2: difference of the two residues of Y, mod m3
        DIF: begin
          r_d_p2  <= w_d;
          r_state <= MUL;
        end
        // p3: scale by m1^-1 mod m3
        MUL: begin
          r_t_p3  <= w_t;
          r_state <= SUM;
        end
        // p4: rebuild Y and append the low residue as the bottom N bits
        SUM: begin
          r_x         <= {w_y, r_r2_p0};
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rns_reverse_converter.sv
module tb_rns_reverse_converter;

  typedef struct {
    int x;
    int acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;

  // N = 7 instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [6:0]  r1, r2;
  logic [7:0]  r3;
  logic [20:0] x;

  // N = 4 instance
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  r1_4, r2_4;
  logic [4:0]  r3_4;
  logic [11:0] x4;

  exp_t q7[$];
  exp_t q4[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic pv7 = 1'b0;
  logic pv4 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rns_reverse_converter #(.N(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r1(r1), .r2(r2), .r3(r3),
    .out_valid(out_valid), .out_ready(out_ready), .x(x)
  );

  rns_reverse_converter #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .r1(r1_4), .r2(r2_4), .r3(r3_4),
    .out_valid(out_valid4), .out_ready(out_ready4), .x(x4)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitors: latency on the rising edge of out_valid, value on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !pv7 && q7.size() > 0)
        chk("latency7", cyc - q7[0].acc, 4);
      if (out_valid && out_ready) begin
        if (q7.size() == 0)
          chk("unexpected_out7", q7.size(), 1);
        else begin
          chk("x7", int'(x), q7[0].x);
          void'(q7.pop_front());
        end
      end
    end
    pv7 <= out_valid;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid4 && !pv4 && q4.size() > 0)
        chk("latency4", cyc - q4[0].acc, 4);
      if (out_valid4 && out_ready4) begin
        if (q4.size() == 0)
          chk("unexpected_out4", q4.size(), 1);
        else begin
          chk("x4", int'(x4), q4[0].x);
          void'(q4.pop_front());
        end
      end
    end
    pv4 <= out_valid4;
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send7(input int a1, input int a2, input int a3,
                       input int ex, input bit push);
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready) chk("accept_timeout7", int'(in_ready), 1);
    r1 = 7'(a1); r2 = 7'(a2); r3 = 8'(a3);
    in_valid = 1'b1;
    if (push) q7.push_back('{ex, cyc + 1});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send4(input int a1, input int a2, input int a3, input int ex);
    int k = 0;
    while (!in_ready4 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready4) chk("accept_timeout4", int'(in_ready4), 1);
    r1_4 = 4'(a1); r2_4 = 4'(a2); r3_4 = 5'(a3);
    in_valid4 = 1'b1;
    q4.push_back('{ex, cyc + 1});
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic wait_valid7();
    int k = 0;
    while (!out_valid && k < 20) begin
      chk("in_ready_busy", int'(in_ready), 0);
      @(posedge clk); #1; k++;
    end
    chk("out_valid_rise", int'(out_valid), 1);
  endtask

  initial begin
    int xv;
    int a1;
    rst = 1'b1;
    in_valid = 1'b0; r1 = '0; r2 = '0; r3 = '0; out_ready = 1'b1;
    in_valid4 = 1'b0; r1_4 = '0; r2_4 = '0; r3_4 = '0; out_ready4 = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_x", int'(x), 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    #2; chk("in_ready_after_rst", int'(in_ready), 1);
    @(posedge clk); #1;

    // Directed vectors
    send7(0, 0, 0, 0, 1'b1);            wait_valid7();
    send7(111, 104, 97, 1000, 1'b1);    wait_valid7();
    chk("int_a", int'(dut.r_a_p1), 7);
    chk("int_b", int'(dut.r_b_p1), 7);
    chk("int_d", int'(dut.r_d_p2), 0);
    chk("int_t", int'(dut.r_t_p3), 0);
    send7(26, 57, 90, 12345, 1'b1);     wait_valid7();
    send7(126, 127, 128, 2097023, 1'b1); wait_valid7();
    send7(127, 0, 0, 0, 1'b1);          wait_valid7();
    @(posedge clk); #1;

    // Backpressure with in_valid held and inputs changing
    out_ready = 1'b0;
    send7(26, 57, 90, 12345, 1'b1);     wait_valid7();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      r1 = 7'(i + 1); r2 = 7'(3 * i); r3 = 8'(5 * i);
      @(posedge clk); #1;
      chk("bp_x", int'(x), 12345);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send7(111, 104, 97, 1000, 1'b1);    wait_valid7();
    @(posedge clk); #1;

    // Reset while in MUL discards the conversion
    send7(111, 104, 97, 1000, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_x", int'(x), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #2; chk("midrst_in_ready_rel", int'(in_ready), 1);
    @(posedge clk); #1;
    send7(111, 104, 97, 1000, 1'b1);    wait_valid7();

    // Sweeps: random N=7 values and exhaustive N=4 range in parallel
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          xv = int'($urandom_range(0, 2097023));
          a1 = xv % 127;
          if (a1 == 0 && xv[0]) a1 = 127;
          send7(a1, xv % 128, xv % 129, xv, 1'b1);
        end
      end
      begin
        for (int v = 0; v < 4080; v++)
          send4((v % 15 == 0 && v[0]) ? 15 : v % 15, v % 16, v % 17, v);
      end
    join

    for (int k = 0; k < 50 && (q7.size() != 0 || q4.size() != 0); k++)
      @(posedge clk);
    #1;
    chk("drain7", q7.size(), 0);
    chk("drain4", q4.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
